scan_reg_chain: RTL and testbench

Parametrised multi-chain scan register for the DFT scan infrastructure, generalising the single scan DFF. It holds WIDTH capture flops split into CHAINS independent serial chains, each CHAIN_LEN = WIDTH/CHAINS bits long. A shadow update register keeps functional outputs stable while test data shifts. A shift counter flags each complete pattern load/unload, and the block sits between the functional logic and the tester-side scan ports.

---
 rtl/scan_reg_chain.sv | 107 ++++++++++
 tb/tb_scan_reg_chain.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/scan_reg_chain.sv
// scan_reg_chain
// Multi-chain scan register with a shadow update register.
//
// WIDTH capture flops are split into CHAINS independent serial chains of
// CHAIN_LEN = WIDTH/CHAINS bits each. Chain c occupies cap[c*L+L-1 : c*L].
// Serial data enters at the chain MSB and moves toward the LSB. The chain
// LSB drives scan_out[c].
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   D          functional data in (WIDTH bits)
//   test_mode  0 = functional, 1 = test (scan/capture/update)
//   scan_en    test mode: 1 = shift, 0 = capture
//   scan_in    serial input, one bit per chain
//   update_en  test mode: load shadow Q from the capture flops
//   Q          registered functional/update output
//   scan_out   serial output, one bit per chain (straight from the flops)
//   shift_done one-cycle pulse after each full CHAIN_LEN-bit shift
module scan_reg_chain #(
  parameter int WIDTH  = 8,
  parameter int CHAINS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  D,
  input  logic              test_mode,
  input  logic              scan_en,
  input  logic [CHAINS-1:0] scan_in,
  input  logic              update_en,
  output logic [WIDTH-1:0]  Q,
  output logic [CHAINS-1:0] scan_out,
  output logic              shift_done
);

  localparam int L  = WIDTH / CHAINS;
  localparam int CW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] upd_q, upd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Every chain moved one position toward its LSB, new bit at its MSB.
  logic [WIDTH-1:0] shift_vec;

  genvar gi;
  generate
    for (gi = 0; gi < CHAINS; gi++) begin : g_chain
      assign shift_vec[gi*L+L-1] = scan_in[gi];
      if (L > 1) begin : g_body
        assign shift_vec[gi*L +: L-1] = cap_q[gi*L+1 +: L-1];
      end
      assign scan_out[gi] = cap_q[gi*L];
    end
  endgenerate

  always_comb begin
    cap_d  = cap_q;
    upd_d  = upd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (!test_mode) begin
      upd_d = D;
      cap_d = D;
      cnt_d = '0;
    end else begin
      // Update uses the pre-edge capture value, so it may coincide with
      // shift or capture on the same edge.
      if (update_en) begin
        upd_d = cap_q;
      end
      if (scan_en) begin
        cap_d = shift_vec;
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        // Capture also aborts any partially shifted pattern.
        cap_d = D;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q  <= '0;
      upd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      upd_q  <= upd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q          = upd_q;
  assign shift_done = done_q;

endmodule

// File: tb/tb_scan_reg_chain.sv
// Directed bench for scan_reg_chain with WIDTH=8, CHAINS=2 (chain length 4).
module tb_scan_reg_chain;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       test_mode;
  logic       scan_en;
  logic [1:0] scan_in;
  logic       update_en;
  logic [7:0] Q;
  logic [1:0] scan_out;
  logic       shift_done;

  int n_checks = 0;
  int n_fail   = 0;

  scan_reg_chain #(.WIDTH(8), .CHAINS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .D          (D),
    .test_mode  (test_mode),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .update_en  (update_en),
    .Q          (Q),
    .scan_out   (scan_out),
    .shift_done (shift_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       tm;
    logic       se;
    logic       ue;
    logic [1:0] si;
    logic [7:0] d;
    logic [7:0] eq;
    logic [1:0] eso;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic tm, input logic se, input logic ue,
                     input logic [1:0] si, input logic [7:0] d,
                     input logic [7:0] eq, input logic [1:0] eso, input logic ed);
    vec_t v;
    v.tm = tm; v.se = se; v.ue = ue; v.si = si; v.d = d;
    v.eq = eq; v.eso = eso; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq,
                           input logic [1:0] eso, input logic ed);
    check({tag, ".Q"}, 32'(Q), 32'(eq));
    check({tag, ".scan_out"}, 32'(scan_out), 32'(eso));
    check({tag, ".shift_done"}, 32'(shift_done), 32'(ed));
  endtask

  initial begin
    // Reset held low with random inputs.
    rst = 1'b0; D = '0; test_mode = 0; scan_en = 0; scan_in = '0; update_en = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      D = 8'($urandom); test_mode = 1'($urandom); scan_en = 1'($urandom);
      scan_in = 2'($urandom); update_en = 1'($urandom);
      @(posedge clk); #1;
      check_all($sformatf("reset%0d", i), 8'h00, 2'b00, 1'b0);
      $display("reset cycle %0d: Q=%h scan_out=%b shift_done=%b", i, Q, scan_out, shift_done);
    end
    @(negedge clk);
    rst = 1'b1;

    //   tm se ue si     D      Q      so     done
    // functional: scan_en/update_en ignored
    add(0, 1, 1, 2'b11, 8'h3C, 8'h3C, 2'b10, 0);
    add(0, 0, 1, 2'b00, 8'hC3, 8'hC3, 2'b01, 0);
    add(0, 1, 0, 2'b11, 8'hC3, 8'hC3, 2'b01, 0);
    // capture A5 then unload with scan_in=0
    add(1, 0, 0, 2'b00, 8'hA5, 8'hC3, 2'b01, 0);
    add(1, 1, 0, 2'b00, 8'hFF, 8'hC3, 2'b10, 0);
    add(1, 1, 0, 2'b00, 8'hFF, 8'hC3, 2'b01, 0);
    add(1, 1, 0, 2'b00, 8'hFF, 8'hC3, 2'b10, 0);
    add(1, 1, 0, 2'b00, 8'hFF, 8'hC3, 2'b00, 1);
    add(1, 0, 0, 2'b00, 8'h00, 8'hC3, 2'b00, 0);
    // load C3: chain0 gets 1,1,0,0 ; chain1 gets 0,0,1,1
    add(1, 1, 0, 2'b01, 8'hFF, 8'hC3, 2'b00, 0);
    add(1, 1, 0, 2'b01, 8'hFF, 8'hC3, 2'b00, 0);
    add(1, 1, 0, 2'b10, 8'hFF, 8'hC3, 2'b00, 0);
    add(1, 1, 0, 2'b10, 8'hFF, 8'hC3, 2'b01, 1);
    // update with capture on the same edge: Q takes the old cap (C3)
    add(1, 0, 1, 2'b00, 8'h5A, 8'hC3, 2'b10, 0);
    // update with shift: Q takes the pre-shift cap
    add(1, 1, 1, 2'b11, 8'h00, 8'h5A, 2'b01, 0);
    add(1, 1, 1, 2'b00, 8'h00, 8'hAD, 2'b10, 0);
    // drop scan_en after 2 shifts, then 4 shifts -> one pulse after those 4
    add(1, 0, 0, 2'b00, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b00, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b00, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b00, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b00, 8'h00, 8'hAD, 2'b00, 1);
    // back-to-back: 8 shifts filling with ones
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b00, 0);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b11, 1);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b11, 0);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b11, 0);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b11, 0);
    add(1, 1, 0, 2'b11, 8'h00, 8'hAD, 2'b11, 1);
    // back to functional
    add(0, 1, 1, 2'b11, 8'h00, 8'h00, 2'b00, 0);

    foreach (vecs[i]) begin
      test_mode = vecs[i].tm; scan_en = vecs[i].se; update_en = vecs[i].ue;
      scan_in = vecs[i].si; D = vecs[i].d;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eso, vecs[i].ed);
      $display("vec %0d: tm=%b se=%b ue=%b si=%b D=%h -> Q=%h scan_out=%b shift_done=%b",
               i, vecs[i].tm, vecs[i].se, vecs[i].ue, vecs[i].si, vecs[i].d,
               Q, scan_out, shift_done);
      @(negedge clk);
    end

    // Asynchronous reset mid-shift.
    test_mode = 1; scan_en = 0; update_en = 1; D = 8'hFF; scan_in = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    scan_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      update_en = 0;
    end
    check("pre_reset.Q", 32'(Q), 32'hFF);
    #2 rst = 1'b0;
    #1;
    check_all("async_reset", 8'h00, 2'b00, 1'b0);
    $display("async reset mid-shift: Q=%h scan_out=%b shift_done=%b", Q, scan_out, shift_done);
    @(negedge clk);
    rst = 1'b1;
    // Count restarts: pulse only after the 4th post-reset shift.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_shift%0d.shift_done", i), 32'(shift_done),
            (i == 3) ? 32'd1 : 32'd0);
      $display("post-reset shift %0d: shift_done=%b", i, shift_done);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
